// File: rtl/fp_addsub_pkg.sv
// Shared geometry, width helpers and stage-1 payload type for the FP add/sub execute stage.
package fp_addsub_pkg;

   localparam int unsigned EXP_DEF   = 5;
   localparam int unsigned MANT_DEF  = 10;
   localparam int unsigned GUARD_DEF = 5;

   function automatic int unsigned sum_w(input int unsigned mant, input int unsigned guard);
      return mant + guard + 2;
   endfunction

   function automatic int unsigned lzc_w(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   localparam int unsigned SUM_W_DEF = sum_w(MANT_DEF, GUARD_DEF);
   localparam int unsigned LZC_W_DEF = lzc_w(SUM_W_DEF);

   // Stage-1 payload at the default geometry: guard-extended operands plus controls.
   typedef struct packed {
      logic [SUM_W_DEF-2:0] x;
      logic [SUM_W_DEF-2:0] y;
      logic                 opr;
      logic                 sgn;
   } s1_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; reports W for an all-zero input.
module fp_lzc
   import fp_addsub_pkg::*;
#(
   parameter int unsigned W = SUM_W_DEF
) (
   input  logic [W-1:0]        din,
   output logic [lzc_w(W)-1:0] cnt_c
);

   localparam int unsigned CW = lzc_w(W);

   // Scan upward so the highest set bit is the last one to write the count.
   always_comb begin
      cnt_c = CW'(W);
      for (int unsigned i = 0; i < W; i++) begin
         if (din[i]) begin
            cnt_c = CW'(W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fp_addsub_exec_pipe.sv
// Two-stage mantissa add/sub execute stage between align and normalise/round.
module fp_addsub_exec_pipe
   import fp_addsub_pkg::*;
#(
   parameter int unsigned EXP   = EXP_DEF,
   parameter int unsigned MANT  = MANT_DEF,
   parameter int unsigned GUARD = GUARD_DEF
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [MANT-1:0]                     mmax,
   input  logic [MANT:0]                       mmin,
   input  logic                                sa,
   input  logic                                sb,
   input  logic                                max_ab,
   input  logic                                op_mode,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [sum_w(MANT, GUARD)-1:0]       sum,
   output logic                                psgn,
   output logic                                opr,
   output logic                                zero,
   output logic                                carry,
   output logic [lzc_w(sum_w(MANT, GUARD))-1:0] lzc
);

   localparam int unsigned SUM_W = sum_w(MANT, GUARD);
   localparam int unsigned LZC_W = lzc_w(SUM_W);
   localparam int unsigned OPW   = SUM_W - 1;

   if (EXP == 0 || MANT == 0 || GUARD == 0) begin : g_param_chk
      $error("fp_addsub_exec_pipe: EXP, MANT and GUARD must be non-zero");
   end

   typedef struct packed {
      logic [OPW-1:0] x;
      logic [OPW-1:0] y;
      logic           opr;
      logic           sgn;
   } stage1_t;

   logic       s1_valid;
   logic       s2_valid;
   logic       s2_ready;
   stage1_t    s1;

   logic [SUM_W-1:0] sum_n;
   logic             sgn_n;
   logic [LZC_W-1:0] lzc_n;

   // Backpressure chain; no combinational path from in_valid to out_valid.
   assign s2_ready  = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_ready;
   assign out_valid = s2_valid;

   // Stage 1: build guard-extended operands and resolve the effective operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (in_valid && in_ready) begin
            s1.x   <= {1'b1, mmax, {GUARD{1'b0}}};
            s1.y   <= {mmin, {GUARD{1'b0}}};
            s1.opr <= op_mode ^ sa ^ sb;
            s1.sgn <= max_ab ? sb : sa;
         end
      end
   end

   // Stage-2 datapath: magnitude is always non-negative; an exact cancel gives +0.
   always_comb begin
      sum_n = SUM_W'(s1.x) + SUM_W'(s1.y);
      sgn_n = s1.sgn;
      if (s1.opr) begin
         if (s1.x >= s1.y) begin
            sum_n = SUM_W'(s1.x - s1.y);
         end else begin
            sum_n = SUM_W'(s1.y - s1.x);
            sgn_n = ~s1.sgn;
         end
         if (sum_n == '0) begin
            sgn_n = 1'b0;
         end
      end
   end

   fp_lzc #(.W(SUM_W)) u_lzc (
      .din   (sum_n),
      .cnt_c (lzc_n)
   );

   // Stage 2: result registers, held while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid <= 1'b0;
         sum      <= '0;
         psgn     <= 1'b0;
         opr      <= 1'b0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         lzc      <= '0;
      end else begin
         if (s2_ready) begin
            s2_valid <= s1_valid;
         end
         if (s1_valid && s2_ready) begin
            sum   <= sum_n;
            psgn  <= sgn_n;
            opr   <= s1.opr;
            zero  <= (sum_n == '0);
            carry <= sum_n[SUM_W-1];
            lzc   <= lzc_n;
         end
      end
   end

endmodule

// File: tb/tb_fp_addsub_exec_pipe.sv
// Scoreboard bench for fp_addsub_exec_pipe at MANT=10, GUARD=5 (SUM_W=17).
module tb_fp_addsub_exec_pipe;
   import fp_addsub_pkg::*;

   localparam int unsigned SW = SUM_W_DEF;
   localparam int unsigned LW = LZC_W_DEF;

   typedef struct {
      logic [SW-1:0] sum;
      logic          psgn;
      logic          opr;
      logic          zero;
      logic          carry;
      logic [LW-1:0] lzc;
      int            acc;
      bit            lat;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [9:0]    mmax;
   logic [10:0]   mmin;
   logic          sa;
   logic          sb;
   logic          max_ab;
   logic          op_mode;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] sum;
   logic          psgn;
   logic          opr;
   logic          zero;
   logic          carry;
   logic [LW-1:0] lzc;

   int   vectors;
   int   miscompares;
   int   cyc;
   int   accepted;
   exp_t sb_q[$];
   logic [25:0] held;
   bit          held_v;

   fp_addsub_exec_pipe #(.EXP(5), .MANT(10), .GUARD(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mmax      (mmax),
      .mmin      (mmin),
      .sa        (sa),
      .sb        (sb),
      .max_ab    (max_ab),
      .op_mode   (op_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .psgn      (psgn),
      .opr       (opr),
      .zero      (zero),
      .carry     (carry),
      .lzc       (lzc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [SW-1:0] s, input logic p, input logic o,
                               input logic z, input logic c, input logic [LW-1:0] l);
      exp_t e;
      e.sum = s; e.psgn = p; e.opr = o; e.zero = z; e.carry = c; e.lzc = l;
      e.acc = 0; e.lat = 1'b0;
      return e;
   endfunction

   // Reference: integer arithmetic on the hidden-bit-extended, guard-shifted operands.
   function automatic exp_t model(input logic [9:0] mm, input logic [10:0] mn,
                                  input logic s_a, input logic s_b, input logic mab, input logic op);
      int x, y, s, l;
      bit o, base, p;
      x = 32768 + int'(mm) * 32;
      y = int'(mn) * 32;
      o = op ^ s_a ^ s_b;
      base = mab ? s_b : s_a;
      p = base;
      if (!o) s = x + y;
      else if (x >= y) s = x - y;
      else begin s = y - x; p = !base; end
      if (o && s == 0) p = 1'b0;
      l = 17;
      for (int i = 0; i < 17; i++) begin
         if (s >= (1 << (16 - i))) begin l = i; break; end
      end
      return mk(SW'(s), p, o, s == 0, s >= 65536, LW'(l));
   endfunction

   task automatic drive(input logic [9:0] mm, input logic [10:0] mn, input logic s_a,
                        input logic s_b, input logic mab, input logic op,
                        input exp_t e, input bit lat);
      int g;
      in_valid = 1'b1; mmax = mm; mmin = mn; sa = s_a; sb = s_b; max_ab = mab; op_mode = op;
      g = 0;
      do begin @(negedge clk); g++; end while (!in_ready && g < 200);
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'(1));
      end else begin
         e.acc = cyc;
         e.lat = lat;
         sb_q.push_back(e);
         accepted++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drive_m(input logic [9:0] mm, input logic [10:0] mn, input logic s_a,
                          input logic s_b, input logic mab, input logic op, input bit lat);
      drive(mm, mn, s_a, s_b, mab, op, model(mm, mn, s_a, s_b, mab, op), lat);
   endtask

   // Output monitor: stall stability and in-order scoreboard pops.
   always @(negedge clk) begin
      logic [25:0] cur;
      exp_t e;
      cur = {sum, psgn, opr, zero, carry, lzc};
      if (!reset && out_valid) begin
         if (!out_ready) begin
            if (held_v) chk("stall_hold", 32'(cur), 32'(held));
            held = cur;
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
            vectors++;
            assert (sb_q.size() > 0) else begin
               miscompares++;
               $error("FAIL unexpected_out observed=%0h expected=none", cur);
            end
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("sum",   32'(sum),   32'(e.sum));
               chk("psgn",  32'(psgn),  32'(e.psgn));
               chk("opr",   32'(opr),   32'(e.opr));
               chk("zero",  32'(zero),  32'(e.zero));
               chk("carry", 32'(carry), 32'(e.carry));
               chk("lzc",   32'(lzc),   32'(e.lzc));
               if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(2));
            end
         end
      end else begin
         held_v = 1'b0;
      end
   end

   initial begin
      int g;
      vectors = 0; miscompares = 0; cyc = 0; accepted = 0; held_v = 1'b0; held = '0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      mmax = '0; mmin = '0; sa = 1'b0; sb = 1'b0; max_ab = 1'b0; op_mode = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready",  32'(in_ready),  32'(1));
      chk("rst_sum",       32'(sum),       32'(0));
      chk("rst_lzc",       32'(lzc),       32'(0));
      @(posedge clk); #1;

      // Directed spec vectors
      drive(10'h000, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0, mk(17'h10000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0),  1'b1);
      repeat (3) @(posedge clk); #1;
      drive(10'h000, 11'h400, 1'b1, 1'b1, 1'b0, 1'b1, mk(17'h00000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd17), 1'b1);
      repeat (3) @(posedge clk); #1;
      drive(10'h000, 11'h600, 1'b0, 1'b0, 1'b0, 1'b1, mk(17'h04000, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2),  1'b1);
      repeat (3) @(posedge clk); #1;
      drive(10'h200, 11'h100, 1'b0, 1'b1, 1'b0, 1'b0, mk(17'h0A000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1),  1'b1);
      repeat (3) @(posedge clk); #1;

      // Back-to-back stream, full throughput, against the model
      drive_m(10'h3FF, 11'h7FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive_m(10'h3FF, 11'h7FF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      drive_m(10'h001, 11'h001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      drive_m(10'h155, 11'h7FE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      repeat (3) @(posedge clk); #1;

      // Backpressure: consumer stalled while six beats stream in
      out_ready = 1'b0;
      accepted = 0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               drive_m(10'(i * 97), 11'(i * 211 + 5), 1'(i), 1'(i >> 1), 1'(i >> 2), 1'(i), 1'b0);
         end
         begin
            @(posedge clk); @(posedge clk); #1;
            chk("bp_in_ready_low", 32'(in_ready), 32'(0));
            chk("bp_accepted",     32'(accepted), 32'(2));
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;

      // Random operands with random consumer stalls
      fork
         begin
            for (int i = 0; i < 12; i++)
               drive_m(10'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 1'b0);
         end
         begin
            repeat (30) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      g = 0;
      while (sb_q.size() != 0 && g < 200) begin @(posedge clk); g++; end
      #1 chk("drain", 32'(sb_q.size()), 32'(0));

      // Async reset with two beats in flight
      drive_m(10'h0AA, 11'h3CC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_m(10'h055, 11'h233, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'(0));
      chk("arst_sum",       32'(sum),       32'(0));
      sb_q.delete();
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_idle", 32'(out_valid), 32'(0));
      end
      @(posedge clk); #1;

      // Recovery after reset
      drive(10'h000, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0, mk(17'h10000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0), 1'b1);
      g = 0;
      while (sb_q.size() != 0 && g < 50) begin @(posedge clk); g++; end
      #1 chk("final_drain", 32'(sb_q.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
